// File: rtl/adc_fsm_10b_v1.sv
// Self-timed 10-bit SAR ADC controller clocked by the comparator done strobe (clkin).
// Supports 10-step, 12-step redundant-correction, and midscale calibration conversions.
module adc_fsm_10b_v1 (
  input  logic       clkin,
  input  logic       rst,
  input  logic       st_conv,
  input  logic       comp_in,
  input  logic       sel_12b,
  input  logic       cal,
  output logic       clkout,
  output logic       sample,
  output logic [9:0] dac_value,
  output logic [4:0] dac_msb,
  output logic [4:0] dac_lsb,
  output logic [9:0] result,
  output logic       adc_done
);

  typedef enum logic [1:0] {IDLE, START, CONV, DONE} state_t;

  state_t     r_state;
  logic [3:0] r_step;
  logic [9:0] r_dac;
  logic [9:0] r_code;
  logic [9:0] r_result;
  logic       r_done;
  logic       r_sample;
  logic       r_cal;

  logic       w_busy;
  logic       w_last;
  logic [9:0] w_mask;
  logic [9:0] w_code;
  logic [9:0] w_trial;
  logic [9:0] w_sat_trial;
  logic [9:0] w_inc;
  logic [9:0] w_dec;
  logic [9:0] w_cnt;

  assign w_busy = (r_state == START) || (r_state == CONV);
  assign clkout = w_busy & ~clkin & ~st_conv;

  // Bit under test this step; zero once past the binary-search phase.
  assign w_mask      = 10'h200 >> r_step;
  assign w_code      = comp_in ? (r_dac | w_mask) : (r_dac & ~w_mask);
  assign w_trial     = w_code | (w_mask >> 1);
  assign w_sat_trial = (w_code == 10'h3FF) ? 10'h3FF : w_code + 10'd1;
  assign w_inc       = (comp_in && r_code != 10'h3FF) ? r_code + 10'd1 : r_code;
  assign w_dec       = (!comp_in && r_code != 10'h000) ? r_code - 10'd1 : r_code;
  assign w_cnt       = r_code + {9'd0, comp_in};
  assign w_last      = sel_12b ? (r_step == 4'd11) : (r_step == 4'd9);

  always_ff @(posedge clkin or posedge rst or posedge st_conv) begin
    if (rst) begin
      r_state  <= IDLE;
      r_step   <= 4'd0;
      r_dac    <= 10'd0;
      r_code   <= 10'd0;
      r_result <= 10'd0;
      r_done   <= 1'b0;
      r_sample <= 1'b0;
      r_cal    <= 1'b0;
    end else if (st_conv) begin
      r_state  <= START;
      r_step   <= 4'd0;
      r_dac    <= 10'h200;
      r_code   <= 10'd0;
      r_done   <= 1'b0;
      r_sample <= 1'b1;
      r_cal    <= cal;
    end else if (w_busy) begin
      r_step   <= r_step + 4'd1;
      r_sample <= 1'b0;
      r_state  <= CONV;
      if (r_cal) begin
        // Calibration: DAC parked at midscale, count comparator ones.
        r_code <= w_cnt;
        if (w_last) begin
          r_result <= w_cnt;
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
      end else if (r_step < 4'd9) begin
        r_dac <= w_trial;
      end else if (r_step == 4'd9) begin
        if (!sel_12b) begin
          r_dac    <= w_code;
          r_result <= w_code;
          r_done   <= 1'b1;
          r_state  <= DONE;
        end else begin
          r_code <= w_code;
          r_dac  <= w_sat_trial;
        end
      end else if (r_step == 4'd10) begin
        r_code <= w_inc;
        r_dac  <= w_inc;
      end else begin
        r_code   <= w_dec;
        r_dac    <= w_dec;
        r_result <= w_dec;
        r_done   <= 1'b1;
        r_state  <= DONE;
      end
    end
  end

  assign dac_value = r_dac;
  assign dac_msb   = r_dac[9:5];
  assign dac_lsb   = r_dac[4:0];
  assign result    = r_result;
  assign adc_done  = r_done;
  assign sample    = r_sample;

endmodule

// File: tb/tb_adc_fsm_10b_v1.sv
// Bench: two controllers (10-step and 12-step) share the analog input, each closed by an ideal comparator model.
module tb_adc_fsm_10b_v1;

  logic       rst = 1'b1;
  logic       st_conv = 1'b0;
  logic       cal = 1'b0;
  logic       force_one = 1'b0;
  logic [9:0] vip = 10'd0;
  int         conv_id = 0;
  int         inv_fire = -1;

  logic       clkin_s [2] = '{1'b0, 1'b0};
  logic       comp_s  [2] = '{1'b0, 1'b0};
  logic       clkout_s[2];
  logic       sample_s[2];
  logic       done_s  [2];
  logic [9:0] dac_s   [2];
  logic [9:0] res_s   [2];
  logic [4:0] msb_s   [2];
  logic [4:0] lsb_s   [2];
  int         fires   [2] = '{0, 0};
  int         seen    [2] = '{-1, -1};
  logic [9:0] fire_dac[2][12];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam logic SEL = (g == 1);

    adc_fsm_10b_v1 u_dut (
      .clkin    (clkin_s[g]),
      .rst      (rst),
      .st_conv  (st_conv),
      .comp_in  (comp_s[g]),
      .sel_12b  (SEL),
      .cal      (cal),
      .clkout   (clkout_s[g]),
      .sample   (sample_s[g]),
      .dac_value(dac_s[g]),
      .dac_msb  (msb_s[g]),
      .dac_lsb  (lsb_s[g]),
      .result   (res_s[g]),
      .adc_done (done_s[g])
    );

    // Ideal comparator: decides on the fire edge, raises done 20 ns later, drops it 5 ns after fire falls.
    always begin : comparator
      logic [9:0] trial;
      logic       r;
      @(posedge clkout_s[g]);
      if (seen[g] != conv_id) begin
        seen[g]  = conv_id;
        fires[g] = 0;
      end
      trial = dac_s[g];
      #20;
      if (clkout_s[g] && !rst) begin
        r = (vip >= trial);
        if (force_one) r = 1'b1;
        if (g == 1 && fires[g] == inv_fire) r = ~r;
        if (fires[g] < 12) fire_dac[g][fires[g]] = trial;
        fires[g]   = fires[g] + 1;
        comp_s[g]  = r;
        clkin_s[g] = 1'b1;
        wait (!clkout_s[g]);
        #5;
        clkin_s[g] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && !(done_s[0] && done_s[1]); i++) #10;
    #10;
    chk("done10", done_s[0], 1);
    chk("done12", done_s[1], 1);
  endtask

  task automatic convert(input logic [9:0] v);
    vip = v;
    conv_id++;
    st_conv = 1'b1;
    #100;
    st_conv = 1'b0;
    wait_done();
  endtask

  initial begin
    #50;
    chk("rst_result", res_s[0], 0);
    chk("rst_done",   done_s[1], 0);
    chk("rst_dac",    dac_s[0], 0);
    chk("rst_sample", sample_s[1], 0);
    chk("rst_clkout", clkout_s[0], 0);
    rst = 1'b0;
    #20;

    // First conversion at vip=0, checking the start-phase outputs while st_conv is held.
    vip = 10'd0;
    conv_id++;
    st_conv = 1'b1;
    #50;
    chk("start_sample", sample_s[0], 1);
    chk("start_dac",    dac_s[0], 10'h200);
    chk("start_clkout", clkout_s[0], 0);
    chk("start_done",   done_s[1], 0);
    #50;
    st_conv = 1'b0;
    wait_done();
    chk("vip0_fires10", fires[0], 10);
    chk("vip0_fires12", fires[1], 12);
    chk("vip0_res10",   res_s[0], 0);
    chk("vip0_res12",   res_s[1], 0);
    chk("vip0_clkout",  clkout_s[0], 0);
    chk("vip0_sample",  sample_s[0], 0);

    convert(10'd693);
    chk("693_msb", msb_s[0], 5'd21);
    chk("693_lsb", lsb_s[0], 5'd21);
    chk("693_dac", dac_s[1], 10'd693);

    // Saturation and underflow guards in the correction steps.
    convert(10'd1023);
    chk("sat_res10",  res_s[0], 1023);
    chk("sat_res12",  res_s[1], 1023);
    chk("sat_trial9", fire_dac[1][9], 1023);
    chk("sat_trial10", fire_dac[1][10], 1023);
    convert(10'd0);
    chk("uf_trial10", fire_dac[1][10], 1);
    chk("uf_trial11", fire_dac[1][11], 0);
    chk("uf_res12",   res_s[1], 0);

    // Wrong step-9 decision on the 12-step controller is repaired by correction.
    inv_fire = 9;
    convert(10'd512);
    inv_fire = -1;
    chk("inv_trial9",  fire_dac[1][9], 513);
    chk("inv_trial10", fire_dac[1][10], 514);
    chk("inv_trial11", fire_dac[1][11], 513);
    chk("inv_res12",   res_s[1], 512);
    chk("inv_res10",   res_s[0], 512);

    // Reset in the middle of a conversion.
    vip = 10'd300;
    conv_id++;
    st_conv = 1'b1;
    #100;
    st_conv = 1'b0;
    for (int i = 0; i < 2000 && fires[1] != 5; i++) #1;
    chk("mid_fires", fires[1], 5);
    rst = 1'b1;
    #1;
    chk("mid_clkout10", clkout_s[0], 0);
    chk("mid_clkout12", clkout_s[1], 0);
    chk("mid_done",     done_s[1], 0);
    chk("mid_result",   res_s[1], 0);
    #40;
    rst = 1'b0;
    #20;
    chk("mid_idle_clkout", clkout_s[1], 0);
    convert(10'd300);
    chk("post_res10", res_s[0], 300);
    chk("post_res12", res_s[1], 300);

    // Calibration with the comparator forced high, restarted partway through.
    cal = 1'b1;
    force_one = 1'b1;
    vip = 10'd5;
    conv_id++;
    st_conv = 1'b1;
    #100;
    st_conv = 1'b0;
    for (int i = 0; i < 2000 && fires[1] != 6; i++) #1;
    #2;
    chk("cal_dac10", dac_s[0], 10'h200);
    chk("cal_dac12", dac_s[1], 10'h200);
    conv_id++;
    st_conv = 1'b1;
    #50;
    chk("cal_rs_dac",    dac_s[1], 10'h200);
    chk("cal_rs_done",   done_s[1], 0);
    chk("cal_rs_sample", sample_s[1], 1);
    #50;
    st_conv = 1'b0;
    wait_done();
    chk("cal_res10",  res_s[0], 10);
    chk("cal_res12",  res_s[1], 12);
    chk("cal_fires",  fires[1], 12);
    chk("cal_dacend", dac_s[1], 10'h200);
    cal = 1'b0;
    force_one = 1'b0;
    #20;

    for (int v = 0; v < 1024; v++) begin
      convert(10'(v));
      chk("sweep10", res_s[0], 32'(v));
      chk("sweep12", res_s[1], 32'(v));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
